// File: rtl/mem_pkg.sv
// Shared definitions for the backing memory and the cache in front of it:
// FSM encoding and the default geometry/latency, so both sides agree on widths.
package mem_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;
    localparam int MEM_LAT    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Register-array storage for cache_backing_mem: one write port, combinational
// read port, four fixed taps on words 0..3, async clear to INIT_VAL.
// Optional parity column when CACHE_BACKING_MEM_PARITY_EN is defined.
module mem_array #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wpar,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rpar,
    output logic [DATA_W-1:0] tap0,
    output logic [DATA_W-1:0] tap1,
    output logic [DATA_W-1:0] tap2,
    output logic [DATA_W-1:0] tap3
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Data words: cleared to INIT_VAL on reset, single write port otherwise
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
    assign tap0  = mem[0];
    assign tap1  = mem[1];
    assign tap2  = mem[2];
    assign tap3  = mem[3];

`ifdef CACHE_BACKING_MEM_PARITY_EN
    logic par_mem [DEPTH];

    // Parity column: reset value matches the even parity of INIT_VAL
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) par_mem[i] <= ^INIT_VAL;
        end else if (we) begin
            par_mem[waddr] <= wpar;
        end
    end

    assign rpar = par_mem[raddr];
`else
    logic unused_wpar;
    assign unused_wpar = wpar;
    assign rpar        = 1'b0;
`endif

endmodule

// File: rtl/cache_backing_mem.sv
// Backing main memory behind the 4-line cache. Single-outstanding req/ack
// with LAT cycles of modelled RAM latency: busy covers LAT cycles, the last
// of which is the one-cycle ack. Commit (write or read capture) happens on
// the edge that enters DONE.
// Optional parity: define CACHE_BACKING_MEM_PARITY_EN.
module cache_backing_mem
    import mem_pkg::*;
#(
    parameter int                ADDR_W   = MEM_ADDR_W,
    parameter int                DATA_W   = MEM_DATA_W,
    parameter int                LAT      = MEM_LAT,
    parameter logic [DATA_W-1:0] INIT_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              par_inject,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              par_err,
    output logic [DATA_W-1:0] ram0,
    output logic [DATA_W-1:0] ram1,
    output logic [DATA_W-1:0] ram2,
    output logic [DATA_W-1:0] ram3
);

    if (LAT < 1 || LAT > 15) begin : g_lat_check
        $error("cache_backing_mem: LAT must be in 1..15");
    end

    mem_state_t        state, state_nx;
    logic [3:0]        cnt;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_pinj;

    // Effective request: live inputs on the accept edge (needed for LAT=1,
    // where accept and commit coincide), latched copy afterwards.
    logic              cur_rw;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_pinj;
    logic              commit;
    logic              wpar;
    logic [DATA_W-1:0] mem_rd;
    logic              mem_rpar;

    assign cur_rw    = (state == IDLE) ? req_rw     : lat_rw;
    assign cur_addr  = (state == IDLE) ? req_addr   : lat_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata  : lat_wdata;
    assign cur_pinj  = (state == IDLE) ? par_inject : lat_pinj;

    // Next-state: IDLE accepts, WAIT counts down, DONE lasts one cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = (LAT == 1) ? DONE : WAIT;
            WAIT:    if (cnt == 4'd1) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign commit = (state_nx == DONE) && (state != DONE);
    assign ack    = (state == DONE);
    assign busy   = (state != IDLE);

    // State, countdown and request latch
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_pinj  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                cnt       <= 4'(LAT - 1);
                lat_rw    <= req_rw;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_pinj  <= par_inject;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Read data capture on commit; held until the next read completes
    always_ff @(posedge clk or posedge clr) begin
        if (clr) rdata <= '0;
        else if (commit && !cur_rw) rdata <= mem_rd;
    end

`ifdef CACHE_BACKING_MEM_PARITY_EN
    assign wpar = (^cur_wdata) ^ cur_pinj;

    // Parity error flag, only meaningful alongside ack of a read
    always_ff @(posedge clk or posedge clr) begin
        if (clr) par_err <= 1'b0;
        else     par_err <= commit && !cur_rw && ((^mem_rd) != mem_rpar);
    end
`else
    logic unused_par;
    assign unused_par = cur_pinj ^ mem_rpar;
    assign wpar       = 1'b0;
    assign par_err    = 1'b0;
`endif

    mem_array #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INIT_VAL(INIT_VAL)
    ) u_array (
        .clk  (clk),
        .clr  (clr),
        .we   (commit && cur_rw),
        .waddr(cur_addr),
        .wdata(cur_wdata),
        .wpar (wpar),
        .raddr(cur_addr),
        .rdata(mem_rd),
        .rpar (mem_rpar),
        .tap0 (ram0),
        .tap1 (ram1),
        .tap2 (ram2),
        .tap3 (ram3)
    );

endmodule

// File: tb/tb_cache_backing_mem.sv
// Directed bench for cache_backing_mem: table of write/read transactions on a
// LAT=3 instance, latency sweep on LAT=1 and LAT=15 instances, plus
// hand-written sequences for held req, mid-sim reset and reset mid-write.
module tb_cache_backing_mem;

    localparam int NDUT = 3;
    localparam int LATS [NDUT] = '{3, 1, 15};

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       req   [NDUT];
    logic       rw    [NDUT];
    logic [7:0] addr  [NDUT];
    logic [7:0] wdata [NDUT];
    logic       pinj  [NDUT];
    logic       ack   [NDUT];
    logic [7:0] rdata [NDUT];
    logic       busy  [NDUT];
    logic       perr  [NDUT];
    logic [7:0] ramv  [NDUT][4];
    logic [7:0] last_rd [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

`ifdef CACHE_BACKING_MEM_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        cache_backing_mem #(.ADDR_W(8), .DATA_W(8), .LAT(LATS[g]), .INIT_VAL(8'h00)) dut (
            .clk(clk), .clr(clr), .req(req[g]), .req_rw(rw[g]), .req_addr(addr[g]),
            .req_wdata(wdata[g]), .par_inject(pinj[g]), .ack(ack[g]), .rdata(rdata[g]),
            .busy(busy[g]), .par_err(perr[g]), .ram0(ramv[g][0]), .ram1(ramv[g][1]),
            .ram2(ramv[g][2]), .ram3(ramv[g][3])
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One transaction on instance s; inputs change and outputs are sampled on negedges
    task automatic txn(input int s, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic pi, input logic [7:0] exp_rd, input logic exp_pe);
        int n;
        @(negedge clk);
        req[s] = 1'b1; rw[s] = w; addr[s] = a; wdata[s] = d; pinj[s] = pi;
        @(posedge clk);
        @(negedge clk);
        req[s] = 1'b0; pinj[s] = 1'b0;
        n = 1;
        while (ack[s] !== 1'b1 && n < 40) begin
            chk("busy_wait", int'(busy[s]), 1);
            @(negedge clk);
            n++;
        end
        chk("ack_latency", n, LATS[s]);
        chk("busy_at_ack", int'(busy[s]), 1);
        if (w) begin
            chk("rdata_held", int'(rdata[s]), int'(last_rd[s]));
            chk("perr_write", int'(perr[s]), 0);
            if (a < 8'd4) chk("ram_tap", int'(ramv[s][a[1:0]]), int'(d));
        end else begin
            chk("rdata", int'(rdata[s]), int'(exp_rd));
            chk("par_err", int'(perr[s]), int'(exp_pe));
            last_rd[s] = exp_rd;
        end
        @(negedge clk);
        chk("ack_one_cycle", int'(ack[s]), 0);
        chk("busy_after", int'(busy[s]), 0);
        chk("rdata_hold_after", int'(rdata[s]), int'(last_rd[s]));
    endtask

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic       pi;
        logic [7:0] exp_rd;
        logic       exp_pe;
    } vec_t;

    vec_t tbl [14];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            req[i] = 0; rw[i] = 0; addr[i] = 0; wdata[i] = 0; pinj[i] = 0; last_rd[i] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", int'(ack[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_rdata", int'(rdata[0]), 0);
        for (int i = 0; i < 4; i++) chk("rst_ram", int'(ramv[0][i]), 0);
        chk("rst_perr", int'(perr[0]), 0);
        clr = 1'b0;

        //            w     addr   data   pi    exp_rd  exp_pe
        tbl[0]  = '{1'b1, 8'h0F, 8'hAF, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 8'h0F, 8'h00, 1'b0, 8'hAF, 1'b0};
        tbl[2]  = '{1'b1, 8'h02, 8'h11, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b0, 8'h02, 8'h00, 1'b0, 8'h11, 1'b0};
        tbl[4]  = '{1'b0, 8'h55, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 8'hFF, 8'h5A, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 8'hFF, 8'h00, 1'b0, 8'h5A, 1'b0};
        tbl[7]  = '{1'b1, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0};
        tbl[9]  = '{1'b1, 8'h03, 8'hC0, 1'b1, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 8'h03, 8'h00, 1'b0, 8'hC0, PAR_ON};
        tbl[11] = '{1'b1, 8'h03, 8'hC0, 1'b0, 8'h00, 1'b0};
        tbl[12] = '{1'b0, 8'h03, 8'h00, 1'b0, 8'hC0, 1'b0};
        tbl[13] = '{1'b0, 8'h0F, 8'h00, 1'b0, 8'hAF, 1'b0};

        for (int i = 0; i < 14; i++)
            txn(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].pi, tbl[i].exp_rd, tbl[i].exp_pe);

        // Latency sweep on the LAT=1 and LAT=15 instances
        txn(1, 1'b1, 8'h10, 8'h33, 1'b0, 8'h00, 1'b0);
        txn(1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h33, 1'b0);
        txn(1, 1'b1, 8'h03, 8'h07, 1'b1, 8'h00, 1'b0);
        txn(1, 1'b0, 8'h03, 8'h00, 1'b0, 8'h07, PAR_ON);
        txn(2, 1'b1, 8'h20, 8'h44, 1'b0, 8'h00, 1'b0);
        txn(2, 1'b0, 8'h20, 8'h00, 1'b0, 8'h44, 1'b0);

        // req held high, reads alternating 01/02; address is scrambled while
        // busy to show that only the accepted request's address is used
        txn(0, 1'b1, 8'h01, 8'h77, 1'b0, 8'h00, 1'b0);
        txn(0, 1'b1, 8'h02, 8'h88, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        req[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h01;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("held_ack", int'(ack[0]), (c % 4 == 2) ? 1 : 0);
            chk("held_busy", int'(busy[0]), (c % 4 == 3) ? 0 : 1);
            if (c % 4 == 0) addr[0] = 8'h55;
            if (c % 4 == 2) begin
                chk("held_rdata", int'(rdata[0]), ((c / 4) % 2 == 0) ? 8'h77 : 8'h88);
                addr[0] = ((c / 4) % 2 == 0) ? 8'h02 : 8'h01;
                if (c == 14) req[0] = 1'b0;
            end
        end
        @(negedge clk);
        chk("held_idle", int'(busy[0]), 0);
        chk("held_last_rdata", int'(rdata[0]), 8'h88);

        // Mid-sim reset held for 3 cycles
        clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_ack", int'(ack[0]), 0);
        chk("mid_rst_busy", int'(busy[0]), 0);
        chk("mid_rst_rdata", int'(rdata[0]), 0);
        for (int i = 0; i < 4; i++) chk("mid_rst_ram", int'(ramv[0][i]), 0);
        clr = 1'b0;

        // Reset one cycle into a write: the write must never commit
        @(negedge clk);
        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'h01; wdata[0] = 8'hE0;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        chk("acc_busy", int'(busy[0]), 1);
        clr = 1'b1;
        @(negedge clk);
        chk("rst_wr_busy", int'(busy[0]), 0);
        clr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rst_wr_noack", int'(ack[0]), 0);
        end
        chk("rst_wr_ram1", int'(ramv[0][1]), 0);
        chk("rst_wr_idle", int'(busy[0]), 0);
        last_rd[0] = 8'h00;
        txn(0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
